// File: rtl/load_store_unit_pkg.sv
// ---------------------------------------------------------------------------
// load_store_unit_pkg
// Shared definitions for the load/store unit and anything that reuses its
// lane-steering helpers (for example a future data cache).
//   lsu_state_t   : FSM states of the load/store unit
//   F3_*          : RV32I load/store funct3 encodings
//   accessLegal() : decides whether a funct3/address pair may go to the bus
// ---------------------------------------------------------------------------
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_RESP = 2'd2,
    DONE      = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // An access is legal when the width exists for that direction (stores
  // have no unsigned variants) and the address is naturally aligned.
  function automatic logic accessLegal(input logic       isStore,
                                       input logic [2:0] funct3,
                                       input logic [1:0] addrLo);
    logic ok;
    ok = 1'b0;
    case (funct3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~addrLo[0];
      F3_W:    ok = (addrLo == 2'b00);
      F3_BU:   ok = ~isStore;
      F3_HU:   ok = ~isStore & ~addrLo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// ---------------------------------------------------------------------------
// load_store_unit_if
// Word-aligned memory bus between the load/store unit and the memory system.
//   mem_valid/mem_ready : request handshake (master drives valid)
//   mem_we              : 1 = write request
//   mem_addr            : word-aligned byte address
//   mem_wdata/mem_wstrb : lane-replicated store data and byte enables
//   mem_rvalid/mem_rdata: read response from the slave
// ---------------------------------------------------------------------------
interface load_store_unit_if;

  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/load_store_unit_align.sv
// ---------------------------------------------------------------------------
// lsu_align
// Purely combinational byte-lane steering shared by the load/store unit.
//   funct3_i     : RV32I width/sign field
//   addrLo_i     : byte offset within the word
//   wdata_i      : raw store data (rs2)
//   rdata_i      : raw read word from the bus
//   storeData_o  : store data replicated across all lanes of its width
//   storeStrb_o  : byte enables for the store
//   loadData_o   : selected lane, sign- or zero-extended to 32 bits
// ---------------------------------------------------------------------------
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addrLo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] storeData_o,
  output logic [3:0]  storeStrb_o,
  output logic [31:0] loadData_o
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  // Replicating the store data into every lane means the memory only has
  // to honour the strobes; it never needs to shift data itself.
  always_comb begin
    storeData_o = wdata_i;
    storeStrb_o = 4'b0000;
    case (funct3_i)
      F3_B: begin
        storeData_o = {4{wdata_i[7:0]}};
        storeStrb_o = 4'b0001 << addrLo_i;
      end
      F3_H: begin
        storeData_o = {2{wdata_i[15:0]}};
        storeStrb_o = addrLo_i[1] ? 4'b1100 : 4'b0011;
      end
      F3_W: begin
        storeStrb_o = 4'b1111;
      end
      default: begin
        storeStrb_o = 4'b0000;
      end
    endcase
  end

  // Pick the addressed byte and halfword out of the returned word.
  always_comb begin
    byteSel = rdata_i[7:0];
    case (addrLo_i)
      2'd0:    byteSel = rdata_i[7:0];
      2'd1:    byteSel = rdata_i[15:8];
      2'd2:    byteSel = rdata_i[23:16];
      default: byteSel = rdata_i[31:24];
    endcase
    halfSel = addrLo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  // funct3[2] selects zero extension; the plain encodings sign-extend.
  always_comb begin
    loadData_o = 32'd0;
    case (funct3_i)
      F3_B:    loadData_o = {{24{byteSel[7]}}, byteSel};
      F3_H:    loadData_o = {{16{halfSel[15]}}, halfSel};
      F3_W:    loadData_o = rdata_i;
      F3_BU:   loadData_o = {24'd0, byteSel};
      F3_HU:   loadData_o = {16'd0, halfSel};
      default: loadData_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Memory-access stage of the multicycle RV32I core. Takes one load/store
// command per start strobe, runs a single word-aligned bus transaction and
// reports completion with an optional register-write request.
//   clk, rstn           : core clock, asynchronous active-low reset
//   start               : one-cycle command strobe (ignored unless idle)
//   is_store, funct3    : access direction and width/sign
//   addr, wdata, rd     : byte address, store data, load destination
//   busy                : command in flight (cycle after start through done)
//   done, fault         : completion pulse and abort flag
//   result              : extended load data, valid with done
//   reg_write_enabled   : write-back request for successful loads to rd!=0
//   reg_write_dest      : latched rd
//   mem                 : bus master port (see load_store_unit_if)
// Parameter TIMEOUT_CYCLES bounds the wait for a read response; 0 disables it.
// ---------------------------------------------------------------------------
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [4:0]  rd,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] result,
  output logic        reg_write_enabled,
  output logic [4:0]  reg_write_dest,
  load_store_unit_if.master mem
);

  // The counter only has to reach TIMEOUT_CYCLES-1, the value seen during
  // the last permitted cycle of waiting.
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST =
    TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  lsu_state_t  state_q, state_d;
  logic        isStore_q, isStore_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [4:0]  rd_q, rd_d;
  logic        fault_q, fault_d;
  logic [31:0] result_q, result_d;
  logic [TW-1:0] timer_q, timer_d;

  logic [31:0] storeData;
  logic [3:0]  storeStrb;
  logic [31:0] loadData;
  logic        inReq;

  lsu_align u_align (
    .funct3_i    (funct3_q),
    .addrLo_i    (addr_q[1:0]),
    .wdata_i     (wdata_q),
    .rdata_i     (mem.mem_rdata),
    .storeData_o (storeData),
    .storeStrb_o (storeStrb),
    .loadData_o  (loadData)
  );

  // State and command registers. The async reset returns to IDLE at once so
  // an in-flight request is withdrawn without producing a done pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      isStore_q <= 1'b0;
      funct3_q  <= 3'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      rd_q      <= 5'd0;
      fault_q   <= 1'b0;
      result_q  <= 32'd0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      isStore_q <= isStore_d;
      funct3_q  <= funct3_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_q      <= rd_d;
      fault_q   <= fault_d;
      result_q  <= result_d;
      timer_q   <= timer_d;
    end
  end

  // Next-state logic. Illegal or misaligned commands jump straight to DONE
  // with a fault so the bus is never touched. Stores finish on the request
  // handshake; loads wait for rvalid, which beats a simultaneous timeout.
  always_comb begin
    state_d   = state_q;
    isStore_d = isStore_q;
    funct3_d  = funct3_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_d      = rd_q;
    fault_d   = fault_q;
    result_d  = result_q;
    timer_d   = timer_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          isStore_d = is_store;
          funct3_d  = funct3;
          addr_d    = addr;
          wdata_d   = wdata;
          rd_d      = rd;
          result_d  = 32'd0;
          timer_d   = '0;
          if (accessLegal(is_store, funct3, addr[1:0])) begin
            fault_d = 1'b0;
            state_d = REQ;
          end else begin
            fault_d = 1'b1;
            state_d = DONE;
          end
        end
      end
      REQ: begin
        if (mem.mem_ready) begin
          timer_d = '0;
          state_d = isStore_q ? DONE : WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (mem.mem_rvalid) begin
          result_d = loadData;
          state_d  = DONE;
        end else if ((TIMEOUT_CYCLES != 0) && (timer_q == TIMER_LAST)) begin
          fault_d = 1'b1;
          state_d = DONE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Core-facing outputs. result_q is only loaded by a successful read, so it
  // is already zero for stores and faults; gating with done keeps it quiet
  // between completions.
  assign busy              = (state_q != IDLE);
  assign done              = (state_q == DONE);
  assign fault             = done & fault_q;
  assign result            = done ? result_q : 32'd0;
  assign reg_write_enabled = done & ~isStore_q & ~fault_q & (rd_q != 5'd0);
  assign reg_write_dest    = rd_q;

  // Bus outputs come straight from latched registers while in REQ, so they
  // cannot change until the handshake; outside REQ everything reads zero.
  assign inReq          = (state_q == REQ);
  assign mem.mem_valid  = inReq;
  assign mem.mem_we     = inReq & isStore_q;
  assign mem.mem_addr   = inReq ? {addr_q[31:2], 2'b00} : 32'd0;
  assign mem.mem_wdata  = (inReq && isStore_q) ? storeData : 32'd0;
  assign mem.mem_wstrb  = (inReq && isStore_q) ? storeStrb : 4'b0000;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
// Directed self-checking bench for load_store_unit (TIMEOUT_CYCLES = 4).
// Each scenario task drives its own stimulus and compares outputs #1 after
// the rising edge against hand-computed values.
// ---------------------------------------------------------------------------
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [4:0]  rd;
  logic        busy;
  logic        done;
  logic        fault;
  logic [31:0] result;
  logic        reg_write_enabled;
  logic [4:0]  reg_write_dest;

  int checks = 0;
  int errors = 0;

  load_store_unit_if busIf ();

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk               (clk),
    .rstn              (rstn),
    .start             (start),
    .is_store          (is_store),
    .funct3            (funct3),
    .addr              (addr),
    .wdata             (wdata),
    .rd                (rd),
    .busy              (busy),
    .done              (done),
    .fault             (fault),
    .result            (result),
    .reg_write_enabled (reg_write_enabled),
    .reg_write_dest    (reg_write_dest),
    .mem               (busIf)
  );

  // 10 time-unit clock.
  always #5 clk = ~clk;

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct packed {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expData;
    logic [3:0]  expStrb;
  } storeVec_t;

  typedef struct packed {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [4:0]  rd;
    logic [31:0] expResult;
  } loadVec_t;

  typedef struct packed {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
  } faultVec_t;

  // Pulse start for one cycle; returns #1 after the edge that consumed it,
  // i.e. in cycle 1 of the command.
  task automatic applyStimulus(input logic st, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic [4:0] r);
    is_store = st;
    funct3   = f3;
    addr     = a;
    wdata    = wd;
    rd       = r;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  // Everything is zero while reset is held.
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, fault, reg_write_enabled} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected 0000", {busy, done, fault, reg_write_enabled});
    end
    checks++;
    if ({result, reg_write_dest} !== 37'd0) begin
      errors++;
      $display("[TB] FAIL reset_data: result=%h dest=%0d expected 0", result, reg_write_dest);
    end
    checks++;
    if ({busIf.mem_valid, busIf.mem_we, busIf.mem_addr, busIf.mem_wdata, busIf.mem_wstrb} !== 70'd0) begin
      errors++;
      $display("[TB] FAIL reset_bus: valid=%b we=%b addr=%h wdata=%h wstrb=%b expected all 0",
               busIf.mem_valid, busIf.mem_we, busIf.mem_addr, busIf.mem_wdata, busIf.mem_wstrb);
    end
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  // Store lane steering and done@2.
  task automatic test_store_steering();
    storeVec_t tab [5] = '{
      '{F3_W, 32'h0000_0100, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1111},
      '{F3_B, 32'h0000_0103, 32'h0000_00A5, 32'hA5A5_A5A5, 4'b1000},
      '{F3_B, 32'h0000_0101, 32'h1234_5678, 32'h7878_7878, 4'b0010},
      '{F3_H, 32'h0000_0102, 32'h1234_ABCD, 32'hABCD_ABCD, 4'b1100},
      '{F3_H, 32'h0000_0100, 32'h1234_ABCD, 32'hABCD_ABCD, 4'b0011}
    };
    busIf.mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, tab[i].f3, tab[i].addr, tab[i].wdata, 5'd9);
      checks++;
      if ({busIf.mem_valid, busIf.mem_we, busIf.mem_addr, done} !== {2'b11, tab[i].addr & 32'hFFFF_FFFC, 1'b0}) begin
        errors++;
        $display("[TB] FAIL store%0d_req: valid=%b we=%b addr=%h done=%b expected 1 1 %h 0",
                 i, busIf.mem_valid, busIf.mem_we, busIf.mem_addr, done, tab[i].addr & 32'hFFFF_FFFC);
      end
      checks++;
      if ({busIf.mem_wdata, busIf.mem_wstrb} !== {tab[i].expData, tab[i].expStrb}) begin
        errors++;
        $display("[TB] FAIL store%0d_lanes: wdata=%h wstrb=%b expected %h %b",
                 i, busIf.mem_wdata, busIf.mem_wstrb, tab[i].expData, tab[i].expStrb);
      end
      @(posedge clk); #1;
      checks++;
      if ({done, fault, reg_write_enabled, result} !== {3'b100, 32'd0}) begin
        errors++;
        $display("[TB] FAIL store%0d_done: done=%b fault=%b rwe=%b result=%h expected 1 0 0 0",
                 i, done, fault, reg_write_enabled, result);
      end
      @(posedge clk); #1;
      checks++;
      if ({busy, done} !== 2'b00) begin
        errors++;
        $display("[TB] FAIL store%0d_idle: busy=%b done=%b expected 0 0", i, busy, done);
      end
    end
  endtask

  // Load extraction/extension with rdata 0x1280FF34 and done@3.
  task automatic test_load_extension();
    loadVec_t tab [9] = '{
      '{F3_B,  32'h0000_0202, 5'd5, 32'hFFFF_FF80},
      '{F3_BU, 32'h0000_0202, 5'd5, 32'h0000_0080},
      '{F3_B,  32'h0000_0201, 5'd6, 32'hFFFF_FFFF},
      '{F3_B,  32'h0000_0203, 5'd6, 32'h0000_0012},
      '{F3_BU, 32'h0000_0200, 5'd7, 32'h0000_0034},
      '{F3_H,  32'h0000_0200, 5'd8, 32'hFFFF_FF34},
      '{F3_HU, 32'h0000_0200, 5'd8, 32'h0000_FF34},
      '{F3_H,  32'h0000_0202, 5'd9, 32'h0000_1280},
      '{F3_W,  32'h0000_0200, 5'd0, 32'h1280_FF34}
    };
    logic expWe;
    busIf.mem_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      expWe = (tab[i].rd != 5'd0);
      applyStimulus(1'b0, tab[i].f3, tab[i].addr, 32'hFFFF_FFFF, tab[i].rd);
      checks++;
      if ({busIf.mem_valid, busIf.mem_we, busIf.mem_wstrb, busIf.mem_addr} !== {2'b10, 4'b0000, 32'h0000_0200}) begin
        errors++;
        $display("[TB] FAIL load%0d_req: valid=%b we=%b wstrb=%b addr=%h expected 1 0 0000 00000200",
                 i, busIf.mem_valid, busIf.mem_we, busIf.mem_wstrb, busIf.mem_addr);
      end
      @(posedge clk); #1;
      checks++;
      if ({busIf.mem_valid, busy, done} !== 3'b010) begin
        errors++;
        $display("[TB] FAIL load%0d_wait: valid=%b busy=%b done=%b expected 0 1 0",
                 i, busIf.mem_valid, busy, done);
      end
      busIf.mem_rvalid = 1'b1;
      busIf.mem_rdata  = 32'h1280_FF34;
      @(posedge clk); #1;
      busIf.mem_rvalid = 1'b0;
      busIf.mem_rdata  = 32'h0;
      checks++;
      if ({done, fault, result} !== {2'b10, tab[i].expResult}) begin
        errors++;
        $display("[TB] FAIL load%0d_result: done=%b fault=%b result=%h expected 1 0 %h",
                 i, done, fault, result, tab[i].expResult);
      end
      checks++;
      if ({reg_write_enabled, reg_write_dest} !== {expWe, tab[i].rd}) begin
        errors++;
        $display("[TB] FAIL load%0d_wb: rwe=%b dest=%0d expected %b %0d",
                 i, reg_write_enabled, reg_write_dest, expWe, tab[i].rd);
      end
      @(posedge clk); #1;
    end
  endtask

  // Illegal/misaligned commands: done@1 with fault, bus untouched.
  task automatic test_faults();
    faultVec_t tab [7] = '{
      '{1'b0, F3_H,   32'h0000_0301},
      '{1'b0, F3_W,   32'h0000_0302},
      '{1'b1, F3_W,   32'h0000_0102},
      '{1'b1, F3_H,   32'h0000_0105},
      '{1'b0, 3'b011, 32'h0000_0300},
      '{1'b1, F3_BU,  32'h0000_0300},
      '{1'b0, 3'b110, 32'h0000_0300}
    };
    busIf.mem_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(tab[i].st, tab[i].f3, tab[i].addr, 32'h5555_AAAA, 5'd4);
      checks++;
      if ({done, fault, busIf.mem_valid, reg_write_enabled, result} !== {4'b1100, 32'd0}) begin
        errors++;
        $display("[TB] FAIL fault%0d_done: done=%b fault=%b valid=%b rwe=%b result=%h expected 1 1 0 0 0",
                 i, done, fault, busIf.mem_valid, reg_write_enabled, result);
      end
      @(posedge clk); #1;
      checks++;
      if ({busy, busIf.mem_valid} !== 2'b00) begin
        errors++;
        $display("[TB] FAIL fault%0d_after: busy=%b valid=%b expected 0 0", i, busy, busIf.mem_valid);
      end
    end
  endtask

  // Stalled request keeps its fields stable; then a missing response times
  // out after four cycles in WAIT_RESP.
  task automatic test_stall_timeout();
    int waitCycles;
    busIf.mem_ready = 1'b0;
    applyStimulus(1'b0, F3_H, 32'h0000_0406, 32'h0, 5'd7);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({busIf.mem_valid, busIf.mem_we, busIf.mem_wstrb, busIf.mem_addr} !== {2'b10, 4'b0000, 32'h0000_0404}) begin
        errors++;
        $display("[TB] FAIL stall%0d_hold: valid=%b we=%b wstrb=%b addr=%h expected 1 0 0000 00000404",
                 i, busIf.mem_valid, busIf.mem_we, busIf.mem_wstrb, busIf.mem_addr);
      end
      if (i < 3) begin
        @(posedge clk); #1;
      end
    end
    busIf.mem_ready = 1'b1;
    waitCycles = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) break;
      waitCycles++;
    end
    busIf.mem_ready = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout_done: done=%b expected 1 within 20 cycles", done);
    end
    checks++;
    if (waitCycles !== 4) begin
      errors++;
      $display("[TB] FAIL timeout_latency: waited %0d cycles expected 4", waitCycles);
    end
    checks++;
    if ({fault, reg_write_enabled, result} !== {2'b10, 32'd0}) begin
      errors++;
      $display("[TB] FAIL timeout_fault: fault=%b rwe=%b result=%h expected 1 0 0",
               fault, reg_write_enabled, result);
    end
    @(posedge clk); #1;
  endtask

  // A response on the last permitted wait cycle beats the timeout.
  task automatic test_rvalid_at_timeout();
    busIf.mem_ready = 1'b1;
    applyStimulus(1'b0, F3_W, 32'h0000_0500, 32'h0, 5'd10);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL edge_wait%0d: done=%b expected 0", i, done);
      end
    end
    busIf.mem_rvalid = 1'b1;
    busIf.mem_rdata  = 32'hCAFE_F00D;
    @(posedge clk); #1;
    busIf.mem_rvalid = 1'b0;
    checks++;
    if ({done, fault, reg_write_enabled, result} !== {3'b101, 32'hCAFE_F00D}) begin
      errors++;
      $display("[TB] FAIL edge_result: done=%b fault=%b rwe=%b result=%h expected 1 0 1 cafef00d",
               done, fault, reg_write_enabled, result);
    end
    @(posedge clk); #1;
  endtask

  // Reset during REQ withdraws the request immediately and yields no done.
  task automatic test_reset_mid_req();
    logic doneSeen;
    busIf.mem_ready = 1'b0;
    applyStimulus(1'b1, F3_W, 32'h0000_0600, 32'h1111_2222, 5'd0);
    checks++;
    if (busIf.mem_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rstreq_valid: valid=%b expected 1", busIf.mem_valid);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if ({busIf.mem_valid, busIf.mem_we, busIf.mem_wstrb, busy, done} !== 8'd0) begin
      errors++;
      $display("[TB] FAIL rstreq_drop: valid=%b we=%b wstrb=%b busy=%b done=%b expected all 0",
               busIf.mem_valid, busIf.mem_we, busIf.mem_wstrb, busy, done);
    end
    doneSeen = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (done) doneSeen = 1'b1;
    end
    rstn = 1'b1;
    busIf.mem_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (done || busIf.mem_valid) doneSeen = 1'b1;
    end
    checks++;
    if (doneSeen !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rstreq_nodone: activity seen=%b expected 0", doneSeen);
    end
  endtask

  // A start while busy is ignored and not queued.
  task automatic test_start_while_busy();
    logic extra;
    busIf.mem_ready = 1'b0;
    applyStimulus(1'b0, F3_W, 32'h0000_0700, 32'h0, 5'd3);
    is_store = 1'b1;
    addr     = 32'h0000_0800;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    checks++;
    if ({busIf.mem_valid, busIf.mem_we, busIf.mem_addr} !== {2'b10, 32'h0000_0700}) begin
      errors++;
      $display("[TB] FAIL busy_ignore: valid=%b we=%b addr=%h expected 1 0 00000700",
               busIf.mem_valid, busIf.mem_we, busIf.mem_addr);
    end
    busIf.mem_ready = 1'b1;
    @(posedge clk); #1;
    busIf.mem_ready  = 1'b0;
    busIf.mem_rvalid = 1'b1;
    busIf.mem_rdata  = 32'h0BAD_F00D;
    @(posedge clk); #1;
    busIf.mem_rvalid = 1'b0;
    checks++;
    if ({done, fault, reg_write_enabled, reg_write_dest, result} !== {3'b101, 5'd3, 32'h0BAD_F00D}) begin
      errors++;
      $display("[TB] FAIL busy_result: done=%b fault=%b rwe=%b dest=%0d result=%h expected 1 0 1 3 0badf00d",
               done, fault, reg_write_enabled, reg_write_dest, result);
    end
    extra = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (busy || busIf.mem_valid) extra = 1'b1;
    end
    checks++;
    if (extra !== 1'b0) begin
      errors++;
      $display("[TB] FAIL busy_noqueue: later activity=%b expected 0", extra);
    end
  endtask

  initial begin
    rstn             = 1'b0;
    start            = 1'b0;
    is_store         = 1'b0;
    funct3           = 3'd0;
    addr             = 32'd0;
    wdata            = 32'd0;
    rd               = 5'd0;
    busIf.mem_ready  = 1'b0;
    busIf.mem_rvalid = 1'b0;
    busIf.mem_rdata  = 32'd0;

    test_reset();
    test_store_steering();
    test_load_extension();
    test_faults();
    test_stall_timeout();
    test_rvalid_at_timeout();
    test_reset_mid_req();
    test_start_while_busy();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
